// File: rtl/riscv_alu_decoder.sv
// riscv_alu_decoder: one-entry registered decode stage for RV32 ALU/branch ops.
// Ports:
//   clk, rst_n        clock and asynchronous active-low reset
//   flush             kills the held bundle and any same-cycle accept
//   in_valid/in_ready upstream handshake (in_ready is combinational)
//   instr             32-bit instruction word
//   out_valid/out_ready downstream handshake
//   alu_op, alu_funct3, alu_funct7, imm, use_imm, rd, rs1, rs2,
//   reg_write, branch, illegal  decoded bundle fields (registered)
//   illegal_seen      sticky flag, set when an illegal bundle is loaded
module riscv_alu_decoder (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [6:0]  alu_op,
  output logic [2:0]  alu_funct3,
  output logic [6:0]  alu_funct7,
  output logic [31:0] imm,
  output logic        use_imm,
  output logic [4:0]  rd,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic        reg_write,
  output logic        branch,
  output logic        illegal,
  output logic        illegal_seen
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned OP_W  = 7;
  localparam int unsigned F3_W  = 3;
  localparam int unsigned F7_W  = 7;
  localparam int unsigned REG_W = 5;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [F7_W-1:0] F7_BASE = 7'b0000000;
  localparam logic [F7_W-1:0] F7_ALT  = 7'b0100000;
  localparam logic [F7_W-1:0] F7_MUL  = 7'b0000001;

  localparam logic [OP_W-1:0] OP_ADD   = 7'h00;
  localparam logic [OP_W-1:0] OP_AND   = 7'h01;
  localparam logic [OP_W-1:0] OP_OR    = 7'h02;
  localparam logic [OP_W-1:0] OP_SUB   = 7'h03;
  localparam logic [OP_W-1:0] OP_XOR   = 7'h04;
  localparam logic [OP_W-1:0] OP_SLT   = 7'h05;
  localparam logic [OP_W-1:0] OP_SHIFT = 7'h07;
  localparam logic [OP_W-1:0] OP_MUL   = 7'h08;
  localparam logic [OP_W-1:0] OP_BEQ   = 7'h20;
  localparam logic [OP_W-1:0] OP_BNE   = 7'h21;
  localparam logic [OP_W-1:0] OP_BLT   = 7'h22;
  localparam logic [OP_W-1:0] OP_BGE   = 7'h23;

  typedef struct packed {
    logic [OP_W-1:0]  alu_op;
    logic [F3_W-1:0]  funct3;
    logic [F7_W-1:0]  funct7;
    logic [XLEN-1:0]  imm;
    logic             use_imm;
    logic [REG_W-1:0] rd;
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
    logic             reg_write;
    logic             branch;
    logic             illegal;
  } bundle_t;

  bundle_t          dec_c;
  bundle_t          held;
  logic             legal_c;
  logic             accept_c;
  logic [6:0]       opcode_c;
  logic [F3_W-1:0]  funct3_c;
  logic [F7_W-1:0]  funct7_c;

  assign in_ready = !out_valid || out_ready;
  assign accept_c = in_valid && in_ready;

  // Combinational decode of the incoming word into a bundle.
  always_comb begin
    opcode_c = instr[6:0];
    funct3_c = instr[14:12];
    funct7_c = instr[31:25];
    legal_c  = 1'b0;
    dec_c        = '0;
    dec_c.funct3 = funct3_c;
    dec_c.rd     = instr[11:7];
    dec_c.rs1    = instr[19:15];
    dec_c.rs2    = instr[24:20];

    case (opcode_c)
      OPC_OP: begin
        legal_c         = 1'b1;
        dec_c.funct7    = funct7_c;
        dec_c.reg_write = 1'b1;
        case ({funct7_c, funct3_c})
          {F7_BASE, 3'b000}: dec_c.alu_op = OP_ADD;
          {F7_BASE, 3'b111}: dec_c.alu_op = OP_AND;
          {F7_BASE, 3'b110}: dec_c.alu_op = OP_OR;
          {F7_BASE, 3'b100}: dec_c.alu_op = OP_XOR;
          {F7_BASE, 3'b010}: dec_c.alu_op = OP_SLT;
          {F7_BASE, 3'b001}: dec_c.alu_op = OP_SHIFT;
          {F7_BASE, 3'b101}: dec_c.alu_op = OP_SHIFT;
          {F7_ALT,  3'b000}: dec_c.alu_op = OP_SUB;
          {F7_ALT,  3'b101}: dec_c.alu_op = OP_SHIFT;
          {F7_MUL,  3'b000}: dec_c.alu_op = OP_MUL;
          default:           legal_c = 1'b0;
        endcase
      end
      OPC_OP_IMM: begin
        legal_c         = 1'b1;
        dec_c.use_imm   = 1'b1;
        dec_c.reg_write = 1'b1;
        dec_c.imm       = {{(XLEN-12){instr[31]}}, instr[31:20]};
        case (funct3_c)
          3'b000: dec_c.alu_op = OP_ADD;
          3'b010: dec_c.alu_op = OP_SLT;
          3'b100: dec_c.alu_op = OP_XOR;
          3'b110: dec_c.alu_op = OP_OR;
          3'b111: dec_c.alu_op = OP_AND;
          // Shift-immediates carry funct7 (SRAI marker) and a zero-extended shamt.
          3'b001, 3'b101: begin
            dec_c.alu_op = OP_SHIFT;
            dec_c.funct7 = funct7_c;
            dec_c.imm    = {{(XLEN-REG_W){1'b0}}, instr[24:20]};
            legal_c      = (funct7_c == F7_BASE) ||
                           ((funct3_c == 3'b101) && (funct7_c == F7_ALT));
          end
          default: legal_c = 1'b0;
        endcase
      end
      OPC_BRANCH: begin
        legal_c      = 1'b1;
        dec_c.branch = 1'b1;
        dec_c.imm    = {{(XLEN-13){instr[31]}}, instr[31], instr[7],
                        instr[30:25], instr[11:8], 1'b0};
        case (funct3_c)
          3'b000:  dec_c.alu_op = OP_BEQ;
          3'b001:  dec_c.alu_op = OP_BNE;
          3'b100:  dec_c.alu_op = OP_BLT;
          3'b101:  dec_c.alu_op = OP_BGE;
          default: legal_c = 1'b0;
        endcase
      end
      default: legal_c = 1'b0;
    endcase

    // Illegal bundles keep register indices and funct3 but zero all control.
    if (!legal_c) begin
      dec_c.illegal   = 1'b1;
      dec_c.alu_op    = '0;
      dec_c.funct7    = '0;
      dec_c.imm       = '0;
      dec_c.use_imm   = 1'b0;
      dec_c.reg_write = 1'b0;
      dec_c.branch    = 1'b0;
    end
  end

  // Output holding register: flush beats load, load beats drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid    <= 1'b0;
      held         <= '0;
      illegal_seen <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept_c) begin
      out_valid <= 1'b1;
      held      <= dec_c;
      if (dec_c.illegal) illegal_seen <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign alu_op     = held.alu_op;
  assign alu_funct3 = held.funct3;
  assign alu_funct7 = held.funct7;
  assign imm        = held.imm;
  assign use_imm    = held.use_imm;
  assign rd         = held.rd;
  assign rs1        = held.rs1;
  assign rs2        = held.rs2;
  assign reg_write  = held.reg_write;
  assign branch     = held.branch;
  assign illegal    = held.illegal;

endmodule

// File: tb/tb_riscv_alu_decoder.sv
// tb_riscv_alu_decoder: directed + randomized check of riscv_alu_decoder
// against a table-driven reference model and a one-entry handshake model.
module tb_riscv_alu_decoder;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic        out_valid;
  logic        out_ready;
  logic [6:0]  alu_op;
  logic [2:0]  alu_funct3;
  logic [6:0]  alu_funct7;
  logic [31:0] imm;
  logic        use_imm;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic        reg_write;
  logic        branch;
  logic        illegal;
  logic        illegal_seen;

  riscv_alu_decoder dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .instr        (instr),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .alu_op       (alu_op),
    .alu_funct3   (alu_funct3),
    .alu_funct7   (alu_funct7),
    .imm          (imm),
    .use_imm      (use_imm),
    .rd           (rd),
    .rs1          (rs1),
    .rs2          (rs2),
    .reg_write    (reg_write),
    .branch       (branch),
    .illegal      (illegal),
    .illegal_seen (illegal_seen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic        use_imm;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        reg_write;
    logic        branch;
    logic        illegal;
  } exp_t;

  // funct3-indexed op tables; -1 marks an unsupported funct3.
  localparam int BASE_OP [8] = '{0, 7, 5, -1, 4, 7, 2, 1};
  localparam int BR_OP   [8] = '{32, 33, -1, -1, 34, 35, -1, -1};

  int   total;
  int   bad;
  exp_t m_b;
  logic m_valid;
  logic m_seen;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [31:0] w);
    exp_t e;
    int   op;
    int   f3v;
    int   f7v;
    int   off;
    e     = '0;
    e.f3  = w[14:12];
    e.rd  = w[11:7];
    e.rs1 = w[19:15];
    e.rs2 = w[24:20];
    f3v   = int'(w[14:12]);
    f7v   = int'(w[31:25]);
    op    = -1;
    case (w[6:0])
      7'h33: begin
        if (f7v == 0)                    op = BASE_OP[f3v];
        else if (f7v == 32 && f3v == 0)  op = 3;
        else if (f7v == 32 && f3v == 5)  op = 7;
        else if (f7v == 1 && f3v == 0)   op = 8;
        if (op >= 0) begin
          e.f7        = w[31:25];
          e.reg_write = 1'b1;
        end
      end
      7'h13: begin
        if (f3v == 1)      op = (f7v == 0) ? 7 : -1;
        else if (f3v == 5) op = (f7v == 0 || f7v == 32) ? 7 : -1;
        else               op = BASE_OP[f3v];
        if (op >= 0) begin
          e.use_imm   = 1'b1;
          e.reg_write = 1'b1;
          if (f3v == 1 || f3v == 5) begin
            e.f7  = w[31:25];
            e.imm = 32'(w[24:20]);
          end else begin
            e.imm = 32'($signed(w) >>> 20);
          end
        end
      end
      7'h63: begin
        op = BR_OP[f3v];
        if (op >= 0) begin
          off = (w[31] ? -4096 : 0) + int'(w[7]) * 2048
              + int'(w[30:25]) * 32 + int'(w[11:8]) * 2;
          e.branch = 1'b1;
          e.imm    = 32'(off);
        end
      end
      default: op = -1;
    endcase
    if (op < 0) e.illegal = 1'b1;
    else        e.op      = 7'(op);
    return e;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    w = $urandom;
    case ($urandom % 4)
      0:       w[6:0] = 7'h33;
      1:       w[6:0] = 7'h13;
      2:       w[6:0] = 7'h63;
      default: w[6:0] = w[6:0];
    endcase
    case ($urandom % 4)
      0:       w[31:25] = 7'h00;
      1:       w[31:25] = 7'h20;
      2:       w[31:25] = 7'h01;
      default: w[31:25] = w[31:25];
    endcase
    return w;
  endfunction

  task automatic compare_all();
    check("out_valid",    32'(out_valid),    32'(m_valid));
    check("illegal_seen", 32'(illegal_seen), 32'(m_seen));
    check("alu_op",       32'(alu_op),       32'(m_b.op));
    check("alu_funct3",   32'(alu_funct3),   32'(m_b.f3));
    check("alu_funct7",   32'(alu_funct7),   32'(m_b.f7));
    check("imm",          imm,               m_b.imm);
    check("use_imm",      32'(use_imm),      32'(m_b.use_imm));
    check("rd",           32'(rd),           32'(m_b.rd));
    check("rs1",          32'(rs1),          32'(m_b.rs1));
    check("rs2",          32'(rs2),          32'(m_b.rs2));
    check("reg_write",    32'(reg_write),    32'(m_b.reg_write));
    check("branch",       32'(branch),       32'(m_b.branch));
    check("illegal",      32'(illegal),      32'(m_b.illegal));
  endtask

  // One clock: drive, check in_ready, advance model on the edge, compare.
  task automatic step(input logic v, input logic [31:0] w, input logic ordy, input logic fl);
    logic rdy_exp;
    in_valid  = v;
    instr     = w;
    out_ready = ordy;
    flush     = fl;
    rdy_exp   = !m_valid || ordy;
    #1;
    check("in_ready", 32'(in_ready), 32'(rdy_exp));
    @(posedge clk);
    if (fl) begin
      m_valid = 1'b0;
    end else if (v && rdy_exp) begin
      m_valid = 1'b1;
      m_b     = model(w);
      if (m_b.illegal) m_seen = 1'b1;
    end else if (ordy) begin
      m_valid = 1'b0;
    end
    #1;
    compare_all();
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    m_b       = '0;
    m_valid   = 1'b0;
    m_seen    = 1'b0;
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    instr     = 32'h0;

    // Reset values before any clock edge.
    #1;
    compare_all();
    #12;
    rst_n = 1'b1;
    #1;
    check("in_ready_after_reset", 32'(in_ready), 32'd1);

    // SUB x10,x10,x11
    step(1'b1, 32'h40B50533, 1'b1, 1'b0);
    check("sub_valid", 32'(out_valid), 32'd1);
    check("sub_op",    32'(alu_op),    32'h03);
    check("sub_f7",    32'(alu_funct7), 32'h20);
    check("sub_rd",    32'(rd),        32'd10);
    check("sub_wr",    32'(reg_write), 32'd1);
    check("sub_imm_sel", 32'(use_imm), 32'd0);

    // ADDI x1,x0,-1
    step(1'b1, 32'hFFF00093, 1'b1, 1'b0);
    check("addi_op",  32'(alu_op),  32'h00);
    check("addi_sel", 32'(use_imm), 32'd1);
    check("addi_imm", imm,          32'hFFFFFFFF);
    check("addi_rd",  32'(rd),      32'd1);

    // BEQ x0,x0,-4
    step(1'b1, 32'hFE000EE3, 1'b1, 1'b0);
    check("beq_op",  32'(alu_op),    32'h20);
    check("beq_br",  32'(branch),    32'd1);
    check("beq_wr",  32'(reg_write), 32'd0);
    check("beq_imm", imm,            32'hFFFFFFFC);

    // Backpressure: BEQ bundle frozen for 3 cycles, then replaced with no bubble.
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 32'h00B50533, 1'b0, 1'b0);
      check("stall_op",    32'(alu_op),    32'h20);
      check("stall_valid", 32'(out_valid), 32'd1);
    end
    step(1'b1, 32'h00B50533, 1'b1, 1'b0);
    check("resume_valid", 32'(out_valid), 32'd1);
    check("resume_op",    32'(alu_op),    32'h00);

    // Illegal opcode, then flush with a same-cycle valid input.
    step(1'b1, 32'h0000007F, 1'b1, 1'b0);
    check("ill_flag", 32'(illegal),      32'd1);
    check("ill_op",   32'(alu_op),       32'h00);
    check("ill_seen", 32'(illegal_seen), 32'd1);
    step(1'b1, 32'h40B50533, 1'b1, 1'b1);
    check("flush_valid", 32'(out_valid),    32'd0);
    check("flush_seen",  32'(illegal_seen), 32'd1);

    // Randomized traffic with backpressure and occasional flush.
    for (int i = 0; i < 400; i++) begin
      step(($urandom % 4) != 0, rand_instr(), ($urandom % 4) != 0, ($urandom % 16) == 0);
    end

    // Asynchronous reset while a bundle is held.
    step(1'b1, 32'h0000007F, 1'b1, 1'b0);
    step(1'b1, 32'h00B50533, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    m_valid = 1'b0;
    m_seen  = 1'b0;
    m_b     = '0;
    check("arst_valid", 32'(out_valid),    32'd0);
    check("arst_seen",  32'(illegal_seen), 32'd0);
    compare_all();
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    in_valid = 1'b0;
    #1;
    check("post_rst_valid", 32'(out_valid), 32'd0);
    compare_all();
    @(posedge clk);
    #1;
    check("post_rst_idle", 32'(out_valid), 32'd0);
    step(1'b1, 32'hFFF00093, 1'b1, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
